div_seq: RTL and testbench

- Parametrised sequential radix-2 restoring divider, one quotient bit per clock.
- Supports signed and unsigned operation, selected per operation.
- Detects divide-by-zero and returns a defined result for it.
- Start/ready/done_tick handshake toward the datapath controller. Shared by ALU-style blocks that need a W-bit quotient and remainder.

---
 rtl/div_seq.sv | 163 ++++++++++++++++
 tb/tb_div_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: sequential radix-2 restoring divider, one quotient bit per clock.
// Signed/unsigned selectable per operation, divide-by-zero flagged with a
// defined result (quo = all ones, rmd = dividend).
// Optional feature: define DIV_ABORT_EN to add the abort_i port, which cancels
// an in-flight operation without touching the result registers.
module div_seq #(
  parameter int W    = 16,
  parameter int CBIT = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         sgn_i,
  input  logic [W-1:0] dvnd_i,
  input  logic [W-1:0] dvsr_i,
`ifdef DIV_ABORT_EN
  input  logic         abort_i,
`endif
  output logic         ready_o,
  output logic         done_tick_o,
  output logic         dbz_o,
  output logic [W-1:0] quo_o,
  output logic [W-1:0] rmd_o
);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_OP, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            dneg_q, dneg_d;   // signed op with negative dividend
  logic            sneg_q, sneg_d;   // signed op with negative divisor
  logic [W-1:0]    dvnd_q, dvnd_d;   // raw dividend, returned as rmd on divide-by-zero
  logic [W-1:0]    dvsr_q, dvsr_d;   // divisor magnitude
  logic [W-1:0]    rh_q, rh_d;       // partial remainder
  logic [W-1:0]    rl_q, rl_d;       // dividend bits shifting out / quotient bits shifting in
  logic [CBIT-1:0] n_q, n_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    rmd_q, rmd_d;
  logic            dbz_q, dbz_d;

  logic            dneg_in, sneg_in;
  logic [W:0]      rh_sh, rh_sub;
  logic            q_bit;
  logic            abort_w;

`ifdef DIV_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  assign dneg_in = sgn_i & dvnd_i[W-1];
  assign sneg_in = sgn_i & dvsr_i[W-1];

  // W+1-bit trial subtraction. rh_sh < 2*|dvsr| always holds, so the
  // difference lies in (-2^W, 2^W): bit W is exactly the borrow.
  assign rh_sh  = {rh_q, rl_q[W-1]};
  assign rh_sub = rh_sh - {1'b0, dvsr_q};
  assign q_bit  = ~rh_sub[W];

  // Next-state, datapath next values and handshake outputs
  always_comb begin
    state_d     = state_q;
    dneg_d      = dneg_q;
    sneg_d      = sneg_q;
    dvnd_d      = dvnd_q;
    dvsr_d      = dvsr_q;
    rh_d        = rh_q;
    rl_d        = rl_q;
    n_d         = n_q;
    quo_d       = quo_q;
    rmd_d       = rmd_q;
    dbz_d       = dbz_q;
    ready_o     = 1'b0;
    done_tick_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          dneg_d  = dneg_in;
          sneg_d  = sneg_in;
          dvnd_d  = dvnd_i;
          dvsr_d  = sneg_in ? -dvsr_i : dvsr_i;
          rl_d    = dneg_in ? -dvnd_i : dvnd_i;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (dvsr_q == '0) begin
          quo_d   = '1;
          rmd_d   = dvnd_q;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          rh_d    = '0;
          n_d     = CBIT'(W);
          state_d = S_OP;
        end
      end
      S_OP: begin
        rh_d = q_bit ? rh_sub[W-1:0] : rh_sh[W-1:0];
        rl_d = {rl_q[W-2:0], q_bit};
        n_d  = n_q - CBIT'(1);
        if (n_q == CBIT'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        quo_d   = (dneg_q ^ sneg_q) ? -rl_q : rl_q;
        rmd_d   = dneg_q ? -rh_q : rh_q;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_tick_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort only bites while busy; results from the cancelled op are dropped
    if (abort_w && (state_q == S_CONV || state_q == S_OP || state_q == S_FIX)) begin
      state_d = S_IDLE;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dneg_q <= 1'b0;
      sneg_q <= 1'b0;
      dvnd_q <= '0;
      dvsr_q <= '0;
      rh_q   <= '0;
      rl_q   <= '0;
      n_q    <= '0;
      quo_q  <= '0;
      rmd_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      dneg_q <= dneg_d;
      sneg_q <= sneg_d;
      dvnd_q <= dvnd_d;
      dvsr_q <= dvsr_d;
      rh_q   <= rh_d;
      rl_q   <= rl_d;
      n_q    <= n_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quo_o = quo_q;
  assign rmd_o = rmd_q;
  assign dbz_o = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized + directed bench for div_seq (W=8) against an
// arithmetic reference model; works with or without DIV_ABORT_EN.
module tb_div_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0, sgn = 1'b0, abort = 1'b0;
  logic [W-1:0] dvnd = '0, dvsr = '0;
  logic         ready_o, done_tick_o, dbz_o;
  logic [W-1:0] quo_o, rmd_o;

  int n_tot = 0, n_pass = 0;

  div_seq #(.W(W), .CBIT(4)) dut (
    .clk(clk), .reset(reset), .start_i(start), .sgn_i(sgn),
    .dvnd_i(dvnd), .dvsr_i(dvsr),
`ifdef DIV_ABORT_EN
    .abort_i(abort),
`endif
    .ready_o(ready_o), .done_tick_o(done_tick_o), .dbz_o(dbz_o),
    .quo_o(quo_o), .rmd_o(rmd_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference arithmetic: SV int division truncates toward zero and % takes
  // the dividend's sign, which is exactly the required signed behaviour.
  function automatic logic [W-1:0] f_q(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    if (b == '0) return '1;
    ai = s ? int'($signed(a)) : int'(a);
    bi = s ? int'($signed(b)) : int'(b);
    return W'(ai / bi);
  endfunction

  function automatic logic [W-1:0] f_r(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    if (b == '0) return a;
    ai = s ? int'($signed(a)) : int'(a);
    bi = s ? int'($signed(b)) : int'(b);
    return W'(ai % bi);
  endfunction

  // Reference model: a busy flag plus a countdown to the completion cycle
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
      m_q <= '0; m_r <= '0; m_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_done) m_busy <= 1'b0;
        else if (abort) m_busy <= 1'b0;
        else begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_done <= 1'b1; m_q <= p_q; m_r <= p_r; m_dbz <= p_dbz;
          end
        end
      end else if (start) begin
        p_q    <= f_q(sgn, dvnd, dvsr);
        p_r    <= f_r(sgn, dvnd, dvsr);
        p_dbz  <= (dvsr == '0);
        m_cnt  <= (dvsr == '0) ? 1 : W + 2;
        m_busy <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("ready", 32'(ready_o), 32'(!m_busy));
    chk("done_tick", 32'(done_tick_o), 32'(m_done));
    chk("quo", 32'(quo_o), 32'(m_q));
    chk("rmd", 32'(rmd_o), 32'(m_r));
    chk("dbz", 32'(dbz_o), 32'(m_dbz));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One operation from idle; measures done_tick cycle (start = cycle 0)
  task automatic run_op(input string nm, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
    int cyc;
    tick(); start = 1'b1; sgn = s; dvnd = a; dvsr = b;
    tick(); start = 1'b0; sgn = 1'($urandom); dvnd = W'($urandom); dvsr = W'($urandom);
    cyc = 1;
    @(negedge clk);
    while (!done_tick_o && cyc < 40) begin @(negedge clk); cyc++; end
    chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({nm, " quo"}, 32'(quo_o), 32'(eq));
    chk({nm, " rmd"}, 32'(rmd_o), 32'(er));
    chk({nm, " dbz"}, 32'(dbz_o), 32'(ed));
  endtask

  initial begin
    int nd;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(ready_o), 32'd1);
    chk("rst done", 32'(done_tick_o), 32'd0);
    chk("rst quo", 32'(quo_o), 32'd0);
    chk("rst rmd", 32'(rmd_o), 32'd0);
    chk("rst dbz", 32'(dbz_o), 32'd0);
    tick(); reset = 1'b0;

    run_op("u200/7",   1'b0, 8'd200, 8'd7,  11, 8'd28, 8'd4,  1'b0);
    run_op("s-100/7",  1'b1, 8'h9C,  8'd7,  11, 8'hF2, 8'hFE, 1'b0);
    run_op("s100/-7",  1'b1, 8'd100, 8'hF9, 11, 8'hF2, 8'h02, 1'b0);
    run_op("u5A/0",    1'b0, 8'h5A,  8'h00, 2,  8'hFF, 8'h5A, 1'b1);
    run_op("s5A/0",    1'b1, 8'h5A,  8'h00, 2,  8'hFF, 8'h5A, 1'b1);
    run_op("u10/3",    1'b0, 8'd10,  8'd3,  11, 8'd3,  8'd1,  1'b0);
    run_op("s80/FF",   1'b1, 8'h80,  8'hFF, 11, 8'h80, 8'h00, 1'b0);
    run_op("uFF/80",   1'b0, 8'hFF,  8'h80, 11, 8'h01, 8'h7F, 1'b0);

    // Second start while busy is ignored
    tick(); start = 1'b1; sgn = 1'b0; dvnd = 8'd50; dvsr = 8'd6;
    tick(); start = 1'b0;
    repeat (3) tick();
    start = 1'b1; dvnd = 8'd9; dvsr = 8'd2;
    tick(); start = 1'b0;
    nd = 0;
    repeat (20) begin @(negedge clk); if (done_tick_o) nd++; end
    chk("busy-start done count", 32'(nd), 32'd1);
    chk("busy-start quo", 32'(quo_o), 32'd8);
    chk("busy-start rmd", 32'(rmd_o), 32'd2);

    // Reset in cycle 5 of an operation
    tick(); start = 1'b1; dvnd = 8'd77; dvsr = 8'd5;
    tick(); start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst ready", 32'(ready_o), 32'd1);
    chk("midrst quo", 32'(quo_o), 32'd0);
    chk("midrst rmd", 32'(rmd_o), 32'd0);
    tick(); reset = 1'b0;
    nd = 0;
    repeat (15) begin @(negedge clk); if (done_tick_o) nd++; end
    chk("midrst done count", 32'(nd), 32'd0);

`ifdef DIV_ABORT_EN
    run_op("pre-abort 10/3", 1'b0, 8'd10, 8'd3, 11, 8'd3, 8'd1, 1'b0);
    tick(); start = 1'b1; dvnd = 8'd99; dvsr = 8'd4;
    tick(); start = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    @(negedge clk);
    chk("abort ready", 32'(ready_o), 32'd1);
    nd = 0;
    repeat (15) begin @(negedge clk); if (done_tick_o) nd++; end
    chk("abort done count", 32'(nd), 32'd0);
    chk("abort quo kept", 32'(quo_o), 32'd3);
    chk("abort rmd kept", 32'(rmd_o), 32'd1);
    run_op("post-abort 99/4", 1'b0, 8'd99, 8'd4, 11, 8'd24, 8'd3, 1'b0);
`endif

    // Random traffic, checked every cycle by the model compare
    repeat (4000) begin
      tick();
      reset = ($urandom_range(399) == 0);
      start = 1'($urandom);
      sgn   = 1'($urandom);
      dvnd  = ($urandom_range(7) == 0) ? 8'h80 : W'($urandom);
      case ($urandom_range(7))
        0:       dvsr = 8'h00;
        1:       dvsr = 8'hFF;
        2:       dvsr = 8'h01;
        3:       dvsr = 8'h80;
        default: dvsr = W'($urandom);
      endcase
`ifdef DIV_ABORT_EN
      abort = ($urandom_range(15) == 0);
`endif
    end
    tick(); reset = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (15) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
